// File: rtl/rx_buffer_controller_if.sv
// Signal bundle for the receive buffer controller: UART-side frame input, bus-side
// pop/control inputs and the status/data outputs, with modports for each side.
interface rx_buffer_controller_if #(
  parameter int DATA_W = 8,
  parameter int LW     = 4
);
  logic              rx_en_i;
  logic              rx_valid_i;
  logic [DATA_W-1:0] rx_data_i;
  logic              rx_parity_err_i;
  logic              rx_frame_err_i;
  logic              tick_i;
  logic              rd_en_i;
  logic              flush_i;
  logic              clr_overrun_i;
  logic [LW-1:0]     thresh_i;
  logic [DATA_W-1:0] rd_data_o;
  logic [1:0]        rd_err_o;
  logic [LW-1:0]     level_o;
  logic              empty_o;
  logic              full_o;
  logic              overrun_o;
  logic              timeout_o;
  logic              irq_o;

  // master drives stimulus and observes status; slave is the controller side
  modport master (
    output rx_en_i, rx_valid_i, rx_data_i, rx_parity_err_i, rx_frame_err_i,
           tick_i, rd_en_i, flush_i, clr_overrun_i, thresh_i,
    input  rd_data_o, rd_err_o, level_o, empty_o, full_o, overrun_o, timeout_o, irq_o
  );

  modport slave (
    input  rx_en_i, rx_valid_i, rx_data_i, rx_parity_err_i, rx_frame_err_i,
           tick_i, rd_en_i, flush_i, clr_overrun_i, thresh_i,
    output rd_data_o, rd_err_o, level_o, empty_o, full_o, overrun_o, timeout_o, irq_o
  );
endinterface

// File: rtl/rx_buffer_controller.sv
// Receive FIFO with first-word fall-through head, sticky overrun, idle-bit
// receive timeout FSM and a registered interrupt combining level/timeout/overrun.
module rx_buffer_controller #(
  parameter int DEPTH        = 8,
  parameter int DATA_W       = 8,
  parameter int TIMEOUT_BITS = 32
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       rx_en_i,
  input  logic                       rx_valid_i,
  input  logic [DATA_W-1:0]          rx_data_i,
  input  logic                       rx_parity_err_i,
  input  logic                       rx_frame_err_i,
  input  logic                       tick_i,
  input  logic                       rd_en_i,
  input  logic                       flush_i,
  input  logic                       clr_overrun_i,
  input  logic [$clog2(DEPTH):0]     thresh_i,
  output logic [DATA_W-1:0]          rd_data_o,
  output logic [1:0]                 rd_err_o,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic                       empty_o,
  output logic                       full_o,
  output logic                       overrun_o,
  output logic                       timeout_o,
  output logic                       irq_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int EW = DATA_W + 2;
  localparam int CW = $clog2(TIMEOUT_BITS + 1);
  localparam logic [CW-1:0] TIMEOUT_VAL = CW'(TIMEOUT_BITS);

  typedef enum logic [1:0] {IDLE, COUNT, TIMEOUT} state_t;

  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [LW-1:0] level_reg, level_next;
  logic          overrun_reg;
  logic          irq_reg;
  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          empty, full, push, pop, drop, activity;
  logic [EW-1:0] head;

  assign empty    = (level_reg == '0);
  assign full     = (level_reg == LW'(DEPTH));
  assign pop      = rd_en_i & ~empty & ~flush_i;
  assign push     = rx_valid_i & rx_en_i & ~flush_i & (~full | pop);
  assign drop     = rx_valid_i & rx_en_i & ~flush_i & full & ~pop;
  assign activity = push | pop;

  always_comb begin
    level_next = level_reg;
    if (flush_i)
      level_next = '0;
    else if (push && !pop)
      level_next = level_reg + LW'(1);
    else if (pop && !push)
      level_next = level_reg - LW'(1);
  end

  // Storage has no reset: a reset empties the FIFO through the pointers/level only.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr_reg] <= {rx_parity_err_i, rx_frame_err_i, rx_data_i};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      level_reg   <= '0;
      overrun_reg <= 1'b0;
    end else begin
      level_reg <= level_next;
      if (flush_i) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
      end else begin
        if (push)
          wr_ptr_reg <= wr_ptr_reg + AW'(1);
        if (pop)
          rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      // a dropped frame in the same cycle as a clear keeps the flag set
      if (drop)
        overrun_reg <= 1'b1;
      else if (clr_overrun_i)
        overrun_reg <= 1'b0;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    if (flush_i) begin
      state_next = IDLE;
      cnt_next   = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          cnt_next = '0;
          if (level_reg != '0)
            state_next = COUNT;
        end
        COUNT: begin
          if (level_next == '0) begin
            state_next = IDLE;
            cnt_next   = '0;
          end else if (activity) begin
            cnt_next = '0;
          end else if (tick_i) begin
            cnt_next = cnt_reg + CW'(1);
            if (cnt_reg + CW'(1) == TIMEOUT_VAL)
              state_next = TIMEOUT;
          end
        end
        TIMEOUT: begin
          if (activity) begin
            cnt_next   = '0;
            state_next = (level_next != '0) ? COUNT : IDLE;
          end
        end
        default: begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      irq_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      irq_reg   <= ((thresh_i != '0) && (level_reg >= thresh_i))
                   | (state_reg == TIMEOUT) | overrun_reg;
    end
  end

  assign head      = mem[rd_ptr_reg];
  assign rd_data_o = empty ? '0 : head[DATA_W-1:0];
  assign rd_err_o  = empty ? '0 : head[EW-1:DATA_W];
  assign level_o   = level_reg;
  assign empty_o   = empty;
  assign full_o    = full;
  assign overrun_o = overrun_reg;
  assign timeout_o = (state_reg == TIMEOUT);
  assign irq_o     = irq_reg;
endmodule

// File: tb/tb_rx_buffer_controller.sv
// Directed bench for rx_buffer_controller: stimulus queues expected entries,
// a negedge monitor checks each popped head against the queue.
module tb_rx_buffer_controller;
  localparam int DEPTH  = 8;
  localparam int DATA_W = 8;
  localparam int LW     = 4;
  localparam int EW     = DATA_W + 2;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  rx_buffer_controller_if #(.DATA_W(DATA_W), .LW(LW)) bus ();

  rx_buffer_controller #(.DEPTH(DEPTH), .DATA_W(DATA_W), .TIMEOUT_BITS(32)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .rx_en_i        (bus.rx_en_i),
    .rx_valid_i     (bus.rx_valid_i),
    .rx_data_i      (bus.rx_data_i),
    .rx_parity_err_i(bus.rx_parity_err_i),
    .rx_frame_err_i (bus.rx_frame_err_i),
    .tick_i         (bus.tick_i),
    .rd_en_i        (bus.rd_en_i),
    .flush_i        (bus.flush_i),
    .clr_overrun_i  (bus.clr_overrun_i),
    .thresh_i       (bus.thresh_i),
    .rd_data_o      (bus.rd_data_o),
    .rd_err_o       (bus.rd_err_o),
    .level_o        (bus.level_o),
    .empty_o        (bus.empty_o),
    .full_o         (bus.full_o),
    .overrun_o      (bus.overrun_o),
    .timeout_o      (bus.timeout_o),
    .irq_o          (bus.irq_o)
  );

  logic [EW-1:0] exp_q [$];
  logic [EW-1:0] mon_exp;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted pop must present the oldest expected entry.
  always @(negedge clk) begin
    if (reset_n === 1'b1 && bus.rd_en_i && !bus.flush_i && !bus.empty_o) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_unexpected: got %h expected no entry", {bus.rd_err_o, bus.rd_data_o});
      end else begin
        mon_exp = exp_q.pop_front();
        $display("pop  data=%h err=%b", bus.rd_data_o, bus.rd_err_o);
        chk("pop_entry", 32'({bus.rd_err_o, bus.rd_data_o}), 32'(mon_exp));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_push(input logic [7:0] d, input logic p, input logic f,
                            input logic rd, input logic store);
    bus.rx_valid_i      = 1'b1;
    bus.rx_data_i       = d;
    bus.rx_parity_err_i = p;
    bus.rx_frame_err_i  = f;
    bus.rd_en_i         = rd;
    if (store)
      exp_q.push_back({p, f, d});
    $display("push data=%h p=%0b f=%0b rd=%0b en=%0b flush=%0b", d, p, f, rd,
             bus.rx_en_i, bus.flush_i);
    step();
    bus.rx_valid_i      = 1'b0;
    bus.rx_parity_err_i = 1'b0;
    bus.rx_frame_err_i  = 1'b0;
    bus.rd_en_i         = 1'b0;
  endtask

  task automatic pop1();
    bus.rd_en_i = 1'b1;
    step();
    bus.rd_en_i = 1'b0;
  endtask

  task automatic tick_n(input int n);
    for (int k = 0; k < n; k++) begin
      bus.tick_i = 1'b1;
      step();
    end
    bus.tick_i = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_level"}, 32'(bus.level_o), 0);
    chk({tag, "_empty"}, 32'(bus.empty_o), 1);
    chk({tag, "_full"}, 32'(bus.full_o), 0);
    chk({tag, "_overrun"}, 32'(bus.overrun_o), 0);
    chk({tag, "_timeout"}, 32'(bus.timeout_o), 0);
    chk({tag, "_irq"}, 32'(bus.irq_o), 0);
    chk({tag, "_rd_data"}, 32'(bus.rd_data_o), 0);
    chk({tag, "_rd_err"}, 32'(bus.rd_err_o), 0);
  endtask

  initial begin
    bus.rx_en_i = 1'b1;      bus.rx_valid_i = 1'b0;     bus.rx_data_i = '0;
    bus.rx_parity_err_i = 0; bus.rx_frame_err_i = 1'b0; bus.tick_i = 1'b0;
    bus.rd_en_i = 1'b0;      bus.flush_i = 1'b0;        bus.clr_overrun_i = 1'b0;
    bus.thresh_i = '0;
    reset_n = 1'b0;
    #2;
    chk_reset_outputs("reset");
    @(negedge clk);
    reset_n = 1'b1;
    step();

    // Fill with threshold 4, then drain in order
    bus.thresh_i = 4'd4;
    for (int i = 0; i < 8; i++) begin
      drive_push(8'(8'h11 + i), 1'b0, 1'b0, 1'b0, 1'b1);
      if (i == 3) begin
        chk("level_at_4", 32'(bus.level_o), 4);
        chk("irq_not_yet", 32'(bus.irq_o), 0);
      end
      if (i == 4)
        chk("irq_thresh", 32'(bus.irq_o), 1);
    end
    chk("full_after_8", 32'(bus.full_o), 1);
    chk("level_8", 32'(bus.level_o), 8);
    for (int i = 0; i < 8; i++) pop1();
    chk("empty_after_drain", 32'(bus.empty_o), 1);
    chk("rd_data_empty", 32'(bus.rd_data_o), 0);
    chk("queue_drained_1", 32'(exp_q.size()), 0);
    bus.thresh_i = '0;
    step();
    chk("irq_cleared", 32'(bus.irq_o), 0);

    // Pop while empty is ignored, simultaneous push still lands
    drive_push(8'h77, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("push_pop_empty_level", 32'(bus.level_o), 1);
    pop1();
    chk("empty_again", 32'(bus.empty_o), 1);

    // Overrun behaviour
    for (int i = 0; i < 8; i++) drive_push(8'(8'h21 + i), 1'b0, 1'b0, 1'b0, 1'b1);
    drive_push(8'hAA, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("overrun_set", 32'(bus.overrun_o), 1);
    chk("overrun_level", 32'(bus.level_o), 8);
    bus.clr_overrun_i = 1'b1; step(); bus.clr_overrun_i = 1'b0;
    chk("overrun_clear", 32'(bus.overrun_o), 0);
    drive_push(8'hAA, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("full_push_pop_level", 32'(bus.level_o), 8);
    chk("full_push_pop_no_ovr", 32'(bus.overrun_o), 0);
    bus.clr_overrun_i = 1'b1;
    drive_push(8'hBB, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.clr_overrun_i = 1'b0;
    chk("overrun_set_wins", 32'(bus.overrun_o), 1);
    bus.clr_overrun_i = 1'b1; step(); bus.clr_overrun_i = 1'b0;
    chk("overrun_clear2", 32'(bus.overrun_o), 0);
    for (int i = 0; i < 8; i++) pop1();
    chk("queue_drained_2", 32'(exp_q.size()), 0);

    // Error flags travel with their data
    drive_push(8'h55, 1'b1, 1'b0, 1'b0, 1'b1);
    drive_push(8'h66, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("head_err_parity", 32'(bus.rd_err_o), 2);
    chk("head_data_55", 32'(bus.rd_data_o), 32'h55);
    pop1();
    chk("head_err_frame", 32'(bus.rd_err_o), 1);
    chk("head_data_66", 32'(bus.rd_data_o), 32'h66);
    pop1();

    // Receive disabled ignores frames
    bus.rx_en_i = 1'b0;
    drive_push(8'h99, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.rx_en_i = 1'b1;
    chk("rx_dis_level", 32'(bus.level_o), 0);

    // Timeout after 32 idle bit periods, then pop clears it
    drive_push(8'hC3, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    tick_n(31);
    chk("timeout_31", 32'(bus.timeout_o), 0);
    tick_n(1);
    chk("timeout_32", 32'(bus.timeout_o), 1);
    step();
    chk("timeout_irq", 32'(bus.irq_o), 1);
    pop1();
    chk("timeout_cleared", 32'(bus.timeout_o), 0);
    step();
    chk("timeout_irq_cleared", 32'(bus.irq_o), 0);

    // A push at tick 31 restarts the count
    drive_push(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    tick_n(31);
    bus.tick_i = 1'b1;
    drive_push(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1);
    bus.tick_i = 1'b0;
    chk("restart_no_timeout", 32'(bus.timeout_o), 0);
    tick_n(31);
    chk("restart_31", 32'(bus.timeout_o), 0);
    tick_n(1);
    chk("restart_32", 32'(bus.timeout_o), 1);
    pop1();
    chk("timeout_pop_nonempty", 32'(bus.timeout_o), 0);
    pop1();
    chk("queue_drained_3", 32'(exp_q.size()), 0);

    // Flush beats a simultaneous push and pop, keeps overrun
    for (int i = 0; i < 8; i++) drive_push(8'(8'h31 + i), 1'b0, 1'b0, 1'b0, 1'b1);
    drive_push(8'hAB, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) pop1();
    chk("pre_flush_level", 32'(bus.level_o), 3);
    bus.flush_i = 1'b1;
    drive_push(8'hCD, 1'b0, 1'b0, 1'b1, 1'b0);
    bus.flush_i = 1'b0;
    exp_q.delete();
    chk("flush_level", 32'(bus.level_o), 0);
    chk("flush_empty", 32'(bus.empty_o), 1);
    chk("flush_overrun_kept", 32'(bus.overrun_o), 1);
    chk("flush_timeout", 32'(bus.timeout_o), 0);

    // Asynchronous reset mid-operation
    for (int i = 0; i < 5; i++) drive_push(8'(8'h41 + i), 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    tick_n(32);
    chk("pre_reset_timeout", 32'(bus.timeout_o), 1);
    chk("pre_reset_level", 32'(bus.level_o), 5);
    step();
    #2;
    reset_n = 1'b0;
    #1;
    chk_reset_outputs("async_reset");
    exp_q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    step();
    bus.rx_en_i = 1'b0;
    drive_push(8'hE1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("post_reset_rx_dis", 32'(bus.level_o), 0);
    bus.rx_en_i = 1'b1;
    drive_push(8'h7E, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("post_reset_push", 32'(bus.level_o), 1);
    pop1();
    chk("queue_drained_4", 32'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
